// File: rtl/alarm_controller.sv
// Alarm sequencer: stores an alarm time, watches the running clock time,
// and sequences ringing, snooze and dismiss. Also owns the alarm-set edit
// field select (00 none, 01 minutes, 10 hours).
module alarm_controller #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_S     = 60,
    parameter int RST_HOUR   = 7,
    parameter int RST_MIN    = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [4:0] hours,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    input  logic       sel,
    input  logic       plus,
    input  logic       minus,
    input  logic       arm_tgl,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_mins,
    output logic [1:0] edit,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzz
);

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

    localparam logic [7:0]  RING_LAST = 8'(RING_S - 1);
    localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60 - 1);
    localparam logic [4:0]  RST_H     = 5'(RST_HOUR);
    localparam logic [5:0]  RST_M     = 6'(RST_MIN);

    state_t      state, state_nxt;
    logic [5:0]  secs_q;
    logic        sel_q;
    logic [7:0]  ring_cnt, ring_nxt;
    logic [11:0] snz_cnt, snz_nxt;
    logic        sec_tick, match_evt, sel_rise, adj_en;

    // Any change of the seconds value counts as a tick, including upstream jumps.
    assign sec_tick  = (secs != secs_q);
    assign match_evt = sec_tick && (secs == 6'd0) &&
                       (hours == alarm_hours) && (mins == alarm_mins);
    assign sel_rise  = enable && sel && !sel_q;
    // Adjust only while editing a field and not while the alarm is active;
    // plus and minus together cancel.
    assign adj_en    = enable && (edit != 2'b00) &&
                       (state == IDLE || state == ARMED) && (plus ^ minus);
    assign buzz      = ringing & secs[0];

    // Previous-cycle samples for tick and button-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            secs_q <= 6'd0;
            sel_q  <= 1'b0;
        end else begin
            secs_q <= secs;
            sel_q  <= enable & sel;
        end
    end

    // Edit field select and alarm time adjust (fields wrap independently).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edit        <= 2'b00;
            alarm_hours <= RST_H;
            alarm_mins  <= RST_M;
        end else begin
            if (!enable)
                edit <= 2'b00;
            else if (sel_rise) begin
                case (edit)
                    2'b00:   edit <= 2'b01;
                    2'b01:   edit <= 2'b10;
                    default: edit <= 2'b00;
                endcase
            end
            if (adj_en && edit == 2'b01) begin
                if (plus) alarm_mins <= (alarm_mins == 6'd59) ? 6'd0 : alarm_mins + 6'd1;
                else      alarm_mins <= (alarm_mins == 6'd0) ? 6'd59 : alarm_mins - 6'd1;
            end
            if (adj_en && edit == 2'b10) begin
                if (plus) alarm_hours <= (alarm_hours == 5'd23) ? 5'd0 : alarm_hours + 5'd1;
                else      alarm_hours <= (alarm_hours == 5'd0) ? 5'd23 : alarm_hours - 5'd1;
            end
        end
    end

    // Next-state and counter update, highest-priority event first.
    always_comb begin
        state_nxt = state;
        ring_nxt  = ring_cnt;
        snz_nxt   = snz_cnt;
        case (state)
            IDLE: if (arm_tgl) state_nxt = ARMED;
            ARMED: begin
                if (arm_tgl) state_nxt = IDLE;
                else if (match_evt) begin
                    state_nxt = RINGING;
                    ring_nxt  = 8'd0;
                end
            end
            RINGING: begin
                if (arm_tgl)      state_nxt = IDLE;
                else if (dismiss) state_nxt = ARMED;
                else if (snooze) begin
                    state_nxt = SNOOZE;
                    snz_nxt   = SNZ_LOAD;
                end else if (sec_tick) begin
                    if (ring_cnt == RING_LAST) state_nxt = ARMED;
                    else                       ring_nxt  = ring_cnt + 8'd1;
                end
            end
            SNOOZE: begin
                if (arm_tgl)      state_nxt = IDLE;
                else if (dismiss) state_nxt = ARMED;
                else if (sec_tick) begin
                    if (snz_cnt == 12'd0) begin
                        state_nxt = RINGING;
                        ring_nxt  = 8'd0;
                    end else
                        snz_nxt = snz_cnt - 12'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ring_cnt <= 8'd0;
            snz_cnt  <= 12'd0;
            armed    <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_nxt;
            snz_cnt  <= snz_nxt;
            armed    <= (state_nxt != IDLE);
            ringing  <= (state_nxt == RINGING);
            snoozing <= (state_nxt == SNOOZE);
        end
    end

endmodule
